calc_alu_seq: RTL and testbench
===============================

# calc_alu_seq

Parametrised sequential ALU for the calculator datapath. It replaces the single-register ALU with a WIDTH-generic unit that has four additions: a valid/ready operand handshake, an internal accumulator for chained operations, iterative shift-add multiply and restoring divide/modulo, and registered error reporting. It sits between the host-driven stimulus/middleware register interface and the result readback path.

## Interface
- WIDTH, 32, operand/result/accumulator width (≥ 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  unit can accept (high only in IDLE)
- op  in  4  operation code
- opnd_a  in  WIDTH  operand A (ignored when use_acc=1)
- opnd_b  in  WIDTH  operand B
- use_acc  in  1  take operand A from accumulator
- out_valid  out  1  one-cycle pulse, result/error valid
- result  out  WIDTH  last result, held between pulses
- error  out  2  00 none, 01 overflow/borrow, 10 divide-by-zero, 11 illegal op
- acc  out  WIDTH  current accumulator

Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
- Opcodes:
  - 0000 NOP
  - 0001 ADD
  - 0010 SUB
  - 0011 MUL
  - 0100 DIV
  - 0101 MOD
  - 0110 AND
  - 0111 OR
  - 1000 XOR
  - 1001 NOT A
  - 1101 LOAD (result=B)
  - 1100 CLEAR (result=0, acc=0)
  - all others illegal
- An operation is accepted on a rising edge with in_valid & in_ready. A and B are captured at acceptance; later input changes have no effect.
- All arithmetic is unsigned modulo 2^WIDTH.
  - ADD: error 01 on carry-out.
  - SUB: error 01 on borrow (B > A).
  - MUL: result is the low WIDTH bits; error 01 if the high WIDTH bits are nonzero.
  - DIV/MOD with B=0: result 0, error 10.
- Illegal op: result 0, error 11.
- Accumulator update:
  - acc ← result on every out_valid with error 00 or 01.
  - acc unchanged on error 10 or 11.
  - NOP produces out_valid with result=acc and error 00.
- State machine:
  - IDLE: in_ready=1. Accept MUL, or DIV/MOD with B≠0 → ITER. Any other accepted op → DONE.
  - ITER: one partial product or quotient bit per cycle, WIDTH cycles, using a counter from WIDTH-1 down to 0 → DONE.
  - DONE: out_valid=1, register result/error/acc → IDLE.
- Reset values: state IDLE, in_ready 1 (after reset), out_valid 0, result 0, error 00, acc 0, counter 0.

## Timing
- Single-cycle ops: accepted at edge k, out_valid high from edge k+1 to k+2. Earliest next accept is edge k+2.
- MUL/DIV/MOD (B≠0): accepted at edge k, in_ready low from k to k+WIDTH+1, out_valid high for the cycle after edge k+WIDTH+1.
- The DIV/MOD-by-zero check is made at acceptance, so that case has single-cycle latency.
- in_valid asserted while in_ready=0 is ignored. The host holds it until it sees in_ready.
- rst_n low mid-ITER: immediate abort to reset values. No out_valid, acc cleared.
- use_acc=1 reads acc as it stands at the accept edge, which includes the preceding op's update. Back-to-back chaining is therefore correct.

## Structure
- Package `calc_pkg`:
  - opcode localparams
  - error code localparams (ERR_NONE, ERR_OVF, ERR_DIV0, ERR_ILLEGAL)
  - state enum (IDLE, ITER, DONE)
- One sub-module, `calc_iter_muldiv`:
  - shift-add multiplier and restoring divider sharing one WIDTH-bit adder and counter
  - start/done interface
  - outputs: quotient, remainder, product high and low
- Top level holds the FSM, the combinational single-cycle ops and the accumulator.

## Test plan
- WIDTH=32, reset, then MUL A=3000, B=25765623 → out_valid exactly 33 edges after accept, result=4282424968, error=01, acc=4282424968.
- ADD A=0xFFFFFFFF, B=1 → next cycle result=0, error=01. Then SUB with use_acc=1, B=1 → result=0xFFFFFFFF, error=01.
- DIV 100/7 → result=14, error=00. MOD 100/7 → result=2. DIV 5/0 → 1-cycle latency, result=0, error=10, acc unchanged (2).
- LOAD B=7, then chained ADD use_acc=1 B=5, then MUL use_acc=1 B=3 → acc 7, 12, 36, each error 00.
  - Also hold in_valid high during ITER with a different op → that op is accepted only after out_valid.
- Pull rst_n low 10 cycles into a MUL → all outputs reach reset values asynchronously, no out_valid pulse.
  - Then op 1111 → result=0, error=11.
  - Then CLEAR → acc=0.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the sequential calculator ALU.
//   - opcode encodings
//   - error codes reported on the error output
//   - top-level FSM state type
//   - needs_iter(): decides whether an accepted op runs through the
//     iterative multiply/divide unit
package calc_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_MOD   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_CLEAR = 4'b1100;
  localparam logic [3:0] OP_LOAD  = 4'b1101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divide/modulo by zero is resolved at acceptance and takes the
  // single-cycle path, so only a nonzero divisor goes iterative.
  function automatic logic needs_iter(input logic [3:0] op, input logic b_zero);
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/calc_iter_muldiv.sv
// calc_iter_muldiv: iterative unsigned multiply / restoring divide.
//   One (WIDTH+1)-bit adder and one down-counter are shared by both modes.
//   Each busy cycle retires one product bit (MUL) or one quotient bit (DIV).
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin WIDTH iterations
//   is_div       mode captured at start: 1 = divide, 0 = multiply
//   a, b         multiply: a * b ; divide: a / b
//   done         high during the final iteration cycle
//   quotient     divide result        (valid after done)
//   remainder    divide remainder     (valid after done)
//   prod_hi      upper WIDTH product bits (valid after done)
//   prod_lo      lower WIDTH product bits (valid after done)
module calc_iter_muldiv
  import calc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = $clog2(WIDTH);

  logic          busy;
  logic          div_mode;
  logic [CW-1:0] cnt;

  // hi: partial-product high half / partial remainder
  // lo: multiplier shifting out + product low half / dividend shifting out + quotient
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;

  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             add_cin;
  logic [WIDTH+1:0] add_full;

  // Divide mode computes {rem,next_bit} - divisor as x + ~y + 1; the carry
  // out of bit WIDTH+1 then means "no borrow", i.e. the subtraction fits.
  always_comb begin
    add_x   = {1'b0, hi};
    add_y   = {1'b0, m};
    add_cin = 1'b0;
    if (div_mode) begin
      add_x   = {hi, lo[WIDTH-1]};
      add_y   = ~{1'b0, m};
      add_cin = 1'b1;
    end
  end

  assign add_full = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      cnt      <= CW'(WIDTH - 1);
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      hi <= '0;
      lo <= is_div ? a : b;
      m  <= is_div ? b : a;
    end else if (busy) begin
      if (div_mode) begin
        if (add_full[WIDTH+1]) begin
          hi <= add_full[WIDTH-1:0];
        end else begin
          hi <= add_x[WIDTH-1:0];
        end
        lo <= {lo[WIDTH-2:0], add_full[WIDTH+1]};
      end else if (lo[0]) begin
        hi <= add_full[WIDTH:1];
        lo <= {add_full[0], lo[WIDTH-1:1]};
      end else begin
        hi <= {1'b0, hi[WIDTH-1:1]};
        lo <= {hi[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign done      = busy && (cnt == '0);
  assign quotient  = lo;
  assign remainder = hi;
  assign prod_hi   = hi;
  assign prod_lo   = lo;

endmodule

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: WIDTH-generic sequential ALU with accumulator.
//   Accepts one operation per in_valid & in_ready handshake, runs it in one
//   cycle (logic ops, add/sub, load/clear, div-by-zero, illegal) or WIDTH
//   cycles (MUL, DIV, MOD), then pulses out_valid with result and error.
//   The accumulator follows every result whose error is none or overflow.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     operation presented
//   in_ready     unit idle and able to accept
//   op           opcode (see calc_pkg)
//   opnd_a       operand A (replaced by acc when use_acc=1)
//   opnd_b       operand B
//   use_acc      take operand A from the accumulator
//   out_valid    one-cycle result strobe
//   result       last result, held between strobes
//   error        last error code, held between strobes
//   acc          accumulator
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  input  logic             use_acc,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       error,
  output logic [WIDTH-1:0] acc
);

  state_t state;
  state_t state_next;

  logic             accept;
  logic             start;
  logic [WIDTH-1:0] a_in;

  logic [3:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  logic             md_done;
  logic [WIDTH-1:0] md_quo;
  logic [WIDTH-1:0] md_rem;
  logic [WIDTH-1:0] md_phi;
  logic [WIDTH-1:0] md_plo;

  logic [WIDTH+1:0] eval_p1;
  logic [WIDTH-1:0] res_p1;
  logic [1:0]       err_p1;

  // Returns {error, result} for the captured operation.
  function automatic logic [WIDTH+1:0] evaluate(
    input logic [3:0]       f_op,
    input logic [WIDTH-1:0] f_a,
    input logic [WIDTH-1:0] f_b,
    input logic [WIDTH-1:0] f_acc,
    input logic [WIDTH-1:0] f_quo,
    input logic [WIDTH-1:0] f_rem,
    input logic [WIDTH-1:0] f_phi,
    input logic [WIDTH-1:0] f_plo
  );
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic [1:0]       e;
    sum = {1'b0, f_a} + {1'b0, f_b};
    r   = '0;
    e   = ERR_NONE;
    case (f_op)
      OP_NOP:   r = f_acc;
      OP_ADD: begin
        r = sum[WIDTH-1:0];
        e = sum[WIDTH] ? ERR_OVF : ERR_NONE;
      end
      OP_SUB: begin
        r = f_a - f_b;
        e = (f_b > f_a) ? ERR_OVF : ERR_NONE;
      end
      OP_MUL: begin
        r = f_plo;
        e = (f_phi != '0) ? ERR_OVF : ERR_NONE;
      end
      OP_DIV: begin
        r = (f_b == '0) ? '0 : f_quo;
        e = (f_b == '0) ? ERR_DIV0 : ERR_NONE;
      end
      OP_MOD: begin
        r = (f_b == '0) ? '0 : f_rem;
        e = (f_b == '0) ? ERR_DIV0 : ERR_NONE;
      end
      OP_AND:   r = f_a & f_b;
      OP_OR:    r = f_a | f_b;
      OP_XOR:   r = f_a ^ f_b;
      OP_NOT:   r = ~f_a;
      OP_CLEAR: r = '0;
      OP_LOAD:  r = f_b;
      default:  e = ERR_ILLEGAL;
    endcase
    return {e, r};
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign a_in     = use_acc ? acc : opnd_a;
  assign start    = accept && needs_iter(op, opnd_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = start ? ITER : DONE;
      ITER: if (md_done) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // p0: operands captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= op;
      a_p0  <= a_in;
      b_p0  <= opnd_b;
    end
  end

  calc_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_div    (op != OP_MUL),
    .a         (a_in),
    .b         (opnd_b),
    .done      (md_done),
    .quotient  (md_quo),
    .remainder (md_rem),
    .prod_hi   (md_phi),
    .prod_lo   (md_plo)
  );

  // p1: result formed from captured operands or iterative unit output
  assign eval_p1 = evaluate(op_p0, a_p0, b_p0, acc, md_quo, md_rem, md_phi, md_plo);
  assign res_p1  = eval_p1[WIDTH-1:0];
  assign err_p1  = eval_p1[WIDTH+1:WIDTH];

  // p2: registered outputs and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      error     <= ERR_NONE;
      acc       <= '0;
    end else if (state == DONE) begin
      out_valid <= 1'b1;
      result    <= res_p1;
      error     <= err_p1;
      if ((err_p1 == ERR_NONE) || (err_p1 == ERR_OVF)) begin
        acc <= res_p1;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_alu_seq.sv
module tb_calc_alu_seq;
  import calc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic        use_acc;
  logic        out_valid;
  logic [31:0] result;
  logic [1:0]  error;
  logic [31:0] acc;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ua;
    logic [31:0] res;
    logic [1:0]  err;
    logic [31:0] acc;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  calc_alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .opnd_a    (opnd_a),
    .opnd_b    (opnd_b),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .result    (result),
    .error     (error),
    .acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat;
    bit got;
    @(negedge clk);
    op = v.op; opnd_a = v.a; opnd_b = v.b; use_acc = v.ua; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (in_ready) got = 1'b1;
      else @(negedge clk);
    end
    check({name, ".accept"}, {63'd0, got}, 64'd1);
    if (!got) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) got = 1'b1;
    end
    check({name, ".seen"}, {63'd0, got}, 64'd1);
    check({name, ".lat"}, 64'(lat), 64'(v.lat));
    check({name, ".result"}, {32'd0, result}, {32'd0, v.res});
    check({name, ".error"}, {62'd0, error}, {62'd0, v.err});
    check({name, ".acc"}, {32'd0, acc}, {32'd0, v.acc});
    @(posedge clk);
    #1 check({name, ".pulse"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    vec_t v;
    int lat;
    bit seen;

    vecs[0]  = '{OP_MUL,   32'd3000,       32'd25765623,   1'b0, 32'd4282424968, ERR_OVF,  32'd4282424968, 33};
    vecs[1]  = '{OP_ADD,   32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          ERR_OVF,  32'd0,          1};
    vecs[2]  = '{OP_SUB,   32'd0,          32'd1,          1'b1, 32'hFFFF_FFFF,  ERR_OVF,  32'hFFFF_FFFF,  1};
    vecs[3]  = '{OP_DIV,   32'd100,        32'd7,          1'b0, 32'd14,         ERR_NONE, 32'd14,         33};
    vecs[4]  = '{OP_MOD,   32'd100,        32'd7,          1'b0, 32'd2,          ERR_NONE, 32'd2,          33};
    vecs[5]  = '{OP_DIV,   32'd5,          32'd0,          1'b0, 32'd0,          ERR_DIV0, 32'd2,          1};
    vecs[6]  = '{OP_LOAD,  32'd0,          32'd7,          1'b0, 32'd7,          ERR_NONE, 32'd7,          1};
    vecs[7]  = '{OP_ADD,   32'hDEAD_BEEF,  32'd5,          1'b1, 32'd12,         ERR_NONE, 32'd12,         1};
    vecs[8]  = '{OP_MUL,   32'd0,          32'd3,          1'b1, 32'd36,         ERR_NONE, 32'd36,         33};
    vecs[9]  = '{OP_AND,   32'hF0F0_1234,  32'h0FF0_FFFF,  1'b0, 32'h00F0_1234,  ERR_NONE, 32'h00F0_1234,  1};
    vecs[10] = '{OP_OR,    32'hF000_0000,  32'h0000_000F,  1'b0, 32'hF000_000F,  ERR_NONE, 32'hF000_000F,  1};
    vecs[11] = '{OP_XOR,   32'hFFFF_0000,  32'h0F0F_0F0F,  1'b0, 32'hF0F0_0F0F,  ERR_NONE, 32'hF0F0_0F0F,  1};
    vecs[12] = '{OP_NOT,   32'h1234_5678,  32'd0,          1'b0, 32'hEDCB_A987,  ERR_NONE, 32'hEDCB_A987,  1};
    vecs[13] = '{OP_NOP,   32'd1,          32'd1,          1'b0, 32'hEDCB_A987,  ERR_NONE, 32'hEDCB_A987,  1};
    vecs[14] = '{OP_SUB,   32'd5,          32'd3,          1'b0, 32'd2,          ERR_NONE, 32'd2,          1};
    vecs[15] = '{OP_MUL,   32'h0001_0000,  32'h0001_0000,  1'b0, 32'd0,          ERR_OVF,  32'd0,          33};
    vecs[16] = '{OP_MOD,   32'd7,          32'd9,          1'b0, 32'd7,          ERR_NONE, 32'd7,          33};

    rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; opnd_a = '0; opnd_b = '0; use_acc = 1'b0;
    #1;
    check("rst.in_ready", {63'd0, in_ready}, 64'd1);
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.result", {32'd0, result}, 64'd0);
    check("rst.error", {62'd0, error}, 64'd0);
    check("rst.acc", {32'd0, acc}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // in_valid held through an iterative op with a different op queued
    @(negedge clk);
    op = OP_MUL; opnd_a = 32'd6; opnd_b = 32'd7; use_acc = 1'b0; in_valid = 1'b1;
    check("hold.ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    op = OP_ADD; opnd_a = 32'd1; opnd_b = 32'd2;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check("hold.lat", 64'(lat), 64'd33);
    check("hold.result", {32'd0, result}, 64'd42);
    check("hold.acc", {32'd0, acc}, 64'd42);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("hold.gap", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("hold.add_valid", {63'd0, out_valid}, 64'd1);
    check("hold.add_result", {32'd0, result}, 64'd3);
    check("hold.add_acc", {32'd0, acc}, 64'd3);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    op = OP_MUL; opnd_a = 32'd3; opnd_b = 32'd5; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort.out_valid", {63'd0, out_valid}, 64'd0);
    check("abort.result", {32'd0, result}, 64'd0);
    check("abort.error", {62'd0, error}, 64'd0);
    check("abort.acc", {32'd0, acc}, 64'd0);
    check("abort.in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort.no_pulse", {63'd0, seen}, 64'd0);

    v = '{OP_LOAD, 32'd0, 32'd9, 1'b0, 32'd9, ERR_NONE, 32'd9, 1};
    run_op(v, "load9");
    v = '{4'b1111, 32'd4, 32'd4, 1'b0, 32'd0, ERR_ILLEGAL, 32'd9, 1};
    run_op(v, "illegal");
    v = '{OP_CLEAR, 32'd4, 32'd4, 1'b0, 32'd0, ERR_NONE, 32'd0, 1};
    run_op(v, "clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
